// File: rtl/tinyalu_core.sv
// TinyALU responder: captures A/B/op on start, returns the result with a one-cycle
// done pulse. Single-cycle ops finish at the capture edge; multiply takes MUL_LAT edges.
module tinyalu_core #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        done,
    output logic [15:0] result,
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      a_q, a_d, b_q, b_d;
    logic [15:0]     prod_q, prod_d;
    logic [15:0]     result_q, result_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (op == OP_MUL) ? MUL : RELEASE;
            MUL: begin
                if (!start)                 state_d = IDLE;
                else if (cnt_q == CNT_LAST) state_d = RELEASE;
            end
            RELEASE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs and datapath
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = 16'(a_q) * 16'(b_q);
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = A;
                    b_d = B;
                    done_d = 1'b1;
                    case (op)
                        OP_NOP: ;
                        OP_ADD: result_d = {7'b0, {1'b0, A} + {1'b0, B}};
                        OP_AND: result_d = {8'b0, A & B};
                        OP_XOR: result_d = {8'b0, A ^ B};
                        OP_MUL: begin
                            done_d = 1'b0;
                            busy_d = 1'b1;
                            cnt_d  = CNT_INIT;
                        end
                        OP_RST: result_d = 16'h0000;
                        default: begin
                            result_d = 16'h0000;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                if (!start) begin
                    busy_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    // with MUL_LAT=2 the product register is not yet loaded at the final edge
                    result_d = (MUL_LAT == 2) ? 16'(a_q) * 16'(b_q) : prod_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_LAST;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule
